dds_sample_gen: RTL and testbench

DDS_SAMPLE_GEN -- requirements
Module: dds_sample_gen

---
 rtl/dds_sample_gen_if.sv | 23 ++
 rtl/dds_sample_gen.sv | 100 ++++++++++
 tb/tb_dds_sample_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dds_sample_gen_if.sv
// Sample-pair stream between the DDS generator (master) and the DAC serializer (slave).
interface dds_sample_gen_if #(
    parameter int unsigned DATA_W = 12
);
    logic [DATA_W-1:0] sample1;
    logic [DATA_W-1:0] sample2;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample1,
        output sample2,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample1,
        input  sample2,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/dds_sample_gen.sv
// Two-channel DDS sine generator with quarter-wave ROM and valid/ready output stage.
// Define DDS_PHASE_OFFSET_EN to apply phase_off to channel 2; otherwise channel 2 mirrors channel 1.
module dds_sample_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DATA_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] tune,
    input  logic [7:0]         phase_off,
    input  logic               phase_clr,
    dds_sample_gen_if.master   smp
);

    localparam logic [11:0] MID = 12'd2048;

    localparam logic [10:0] QTAB [0:64] = '{
        11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
        11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
        11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
        11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
        11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
        11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
        11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
        11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
        11'd2047
    };

    // Quadrant bit 6 mirrors the ROM index, bit 7 negates around mid-scale.
    function automatic logic [11:0] wave(input logic [7:0] idx);
        logic [6:0]  k;
        logic [10:0] q;
        k = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        q = QTAB[k];
        return idx[7] ? (MID - {1'b0, q}) : (MID + {1'b0, q});
    endfunction

    logic [PHASE_W-1:0] acc_q;
    logic [11:0]        s1_q;
    logic [11:0]        s2_q;
    logic               valid_q;

    logic               load;
    logic [PHASE_W-1:0] acc_base;
    logic [PHASE_W-1:0] acc_next;
    logic [7:0]         p1;
    logic [7:0]         p2;
    logic [7:0]         phase_2;

`ifdef DDS_PHASE_OFFSET_EN
    assign phase_2 = phase_off;
`else
    logic unused_phase_off;
    assign unused_phase_off = ^phase_off;
    assign phase_2 = 8'd0;
`endif

    always_comb begin
        load     = en && (!valid_q || smp.sample_ready);
        acc_base = phase_clr ? '0 : acc_q;
        acc_next = acc_base + tune;
        p1       = acc_base[PHASE_W-1 -: 8];
        p2       = p1 + phase_2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            s1_q    <= MID;
            s2_q    <= MID;
            valid_q <= 1'b0;
        end else if (load) begin
            acc_q   <= acc_next;
            s1_q    <= wave(p1);
            s2_q    <= wave(p2);
            valid_q <= 1'b1;
        end else begin
            if (phase_clr) begin
                acc_q <= '0;
            end
            // Without a load, a ready cycle can only be draining the last pair.
            if (smp.sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign smp.sample_valid = valid_q;

    // Samples are left-aligned so mid-scale stays mid-scale at any DAC width.
    if (DATA_W >= 12) begin : g_wide
        assign smp.sample1 = DATA_W'(s1_q) << (DATA_W - 12);
        assign smp.sample2 = DATA_W'(s2_q) << (DATA_W - 12);
    end else begin : g_narrow
        assign smp.sample1 = s1_q[11 -: DATA_W];
        assign smp.sample2 = s2_q[11 -: DATA_W];
    end

endmodule

// File: tb/tb_dds_sample_gen.sv
// Directed, table-driven bench for dds_sample_gen: LUT mapping, handshake, clear/wrap, reset.
module tb_dds_sample_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] tune;
    logic [7:0]  phase_off;
    logic        phase_clr;
    logic        ready;

    int n_chk  = 0;
    int n_fail = 0;

    dds_sample_gen_if #(.DATA_W(12)) smp_if ();
    assign smp_if.sample_ready = ready;

    dds_sample_gen #(
        .PHASE_W (32),
        .DATA_W  (12)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .tune      (tune),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .smp       (smp_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    typedef struct {
        int p;
        int off;
        int e1;
        int e2;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int e1, input int e2, input int ev);
        chk({name, " s1"}, 32'(smp_if.sample1), e1);
        chk({name, " s2"}, 32'(smp_if.sample2), e2);
        chk({name, " valid"}, 32'(smp_if.sample_valid), ev);
    endtask

    initial begin
        int e2;

        vecs[0]  = '{0,   64, 2048, 4095};
        vecs[1]  = '{1,   4,  2098, 2299};
        vecs[2]  = '{5,   0,  2299, 2299};
        vecs[3]  = '{32,  0,  3495, 3495};
        vecs[4]  = '{64,  64, 4095, 2048};
        vecs[5]  = '{65,  0,  4094, 4094};
        vecs[6]  = '{100, 0,  3347, 3347};
        vecs[7]  = '{128, 0,  2048, 2048};
        vecs[8]  = '{150, 0,  996,  996};
        vecs[9]  = '{192, 0,  1,    1};
        vecs[10] = '{200, 100, 40,  3853};
        vecs[11] = '{255, 0,  1998, 1998};

        rst_n = 1'b0; en = 1'b0; tune = '0; phase_off = '0; phase_clr = 1'b0; ready = 1'b1;

        // Reset and idle with en low
        repeat (3) tick();
        chk_out("in_reset", 2048, 2048, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk_out("idle_after_reset", 2048, 2048, 0);

        // Latency and sweep with tune = 2^24
        en = 1'b1; tune = 32'h0100_0000;
        tick();
        chk_out("first_sample_p0", 2048, 2048, 1);
        for (int n = 1; n <= 256; n++) begin
            tick();
            if (n == 64)  chk_out("sweep_p64", 4095, 4095, 1);
            if (n == 128) chk_out("sweep_p128", 2048, 2048, 1);
            if (n == 192) chk_out("sweep_p192", 1, 1, 1);
            if (n == 256) chk_out("sweep_p256", 2048, 2048, 1);
        end

        // Stall on p=5 for 10 cycles; tune changed mid-stall applies at the next load
        repeat (5) tick();
        chk_out("pre_stall_p5", 2299, 2299, 1);
        ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) tune = 32'h0200_0000;
            tick();
            chk("stall_hold_s1", 32'(smp_if.sample1), 2299);
            chk("stall_hold_valid", 32'(smp_if.sample_valid), 1);
        end
        ready = 1'b1;
        tick();
        chk_out("after_stall_p6", 2348, 2348, 1);
        tick();
        chk_out("new_tune_p8", 2447, 2447, 1);
        tune = 32'h0100_0000;

        // Mid-stall asynchronous reset
        ready = 1'b0;
        repeat (2) tick();
        chk("stall_pending_valid", 32'(smp_if.sample_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2048, 2048, 0);
        tick();
        rst_n = 1'b1; ready = 1'b1;
        tick();
        chk_out("post_reset_p0", 2048, 2048, 1);
        tick();
        chk_out("post_reset_p1", 2098, 2098, 1);

        // Table: clear-load with tune = p<<24 positions acc, next load samples p
        for (int v = 0; v < 12; v++) begin
            phase_clr = 1'b1; tune = 32'(vecs[v].p) << 24; phase_off = 8'(vecs[v].off);
            tick();
            phase_clr = 1'b0;
            tick();
`ifdef DDS_PHASE_OFFSET_EN
            e2 = vecs[v].e2;
`else
            e2 = vecs[v].e1;
`endif
            chk($sformatf("vec%0d_s1", v), 32'(smp_if.sample1), vecs[v].e1);
            chk($sformatf("vec%0d_s2", v), 32'(smp_if.sample2), e2);
        end
        phase_off = '0;

        // Negative tune wraps downward; clear during a load
        phase_clr = 1'b1; tune = 32'hFF00_0000;
        tick();
        chk_out("wrap_p0", 2048, 2048, 1);
        phase_clr = 1'b0;
        tick();
        chk_out("wrap_p255", 1998, 1998, 1);
        tick();
        chk_out("wrap_p254", 1948, 1948, 1);
        tick();
        chk_out("wrap_p253", 1897, 1897, 1);
        phase_clr = 1'b1;
        tick();
        chk_out("clr_load_p0", 2048, 2048, 1);
        phase_clr = 1'b0;
        tick();
        chk_out("after_clr_p255", 1998, 1998, 1);

        // Clear without load: outputs hold, acc zeroed
        en = 1'b0; ready = 1'b0; phase_clr = 1'b1;
        tick();
        chk_out("clr_noload_hold", 1998, 1998, 1);
        phase_clr = 1'b0; en = 1'b1; ready = 1'b1;
        tick();
        chk_out("after_clr_noload_p0", 2048, 2048, 1);

        // en low with ready high drains the last pair
        en = 1'b0;
        tick();
        chk_out("drain_en_low", 2048, 2048, 0);
        tick();
        chk_out("idle_en_low", 2048, 2048, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
